// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the CPU/debug memory port arbiter.
// Command encodings, I/O addresses, requester IDs and the address-space tag.
package mem_port_arbiter_pkg;

   localparam int AW = 9;
   localparam int DW = 16;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [AW-1:0] LED_ADDR = 9'h100;
   localparam logic [AW-1:0] SW_ADDR  = 9'h140;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   // Source of the read data returned one cycle after a read grant.
   typedef enum logic [1:0] {
      SP_RAM  = 2'd0,
      SP_LED  = 2'd1,
      SP_SW   = 2'd2,
      SP_NONE = 2'd3
   } space_e;

   // Code 11 is treated as no request.
   function automatic logic is_req(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a CPU lock.
// Grant is combinational; only the last winner is registered.
module mem_port_arbiter_rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_lock,
   output logic [1:0] o_gnt
);

   logic r_last_gnt;
   logic w_cpu_elig;
   logic w_dbg_elig;

   // Gating with reset keeps both grants low for the whole reset window.
   assign w_cpu_elig = i_req[0] & ~i_lock & i_rst_n;
   assign w_dbg_elig = i_req[1] & i_rst_n;

   always_comb begin
      o_gnt = 2'b00;
      if (w_cpu_elig && w_dbg_elig) begin
         o_gnt = (r_last_gnt == REQ_DBG) ? 2'b01 : 2'b10;
      end else begin
         o_gnt = {w_dbg_elig, w_cpu_elig};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_gnt <= REQ_DBG;
      end else if (|o_gnt) begin
         r_last_gnt <= o_gnt[1];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between CPU and debug requesters and decodes
// the LED register and switch input in the I/O space (address bit 8 set).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [1:0]    i_cpu_cmd,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   output logic          o_cpu_gnt,
   output logic          o_cpu_rvalid,
   output logic [DW-1:0] o_cpu_rdata,
   input  logic [1:0]    i_dbg_cmd,
   input  logic [AW-1:0] i_dbg_addr,
   input  logic [DW-1:0] i_dbg_wdata,
   output logic          o_dbg_gnt,
   output logic          o_dbg_rvalid,
   output logic [DW-1:0] o_dbg_rdata,
   input  logic          i_dbg_lock,
   output logic [7:0]    o_mem_addr,
   output logic          o_mem_write,
   output logic [DW-1:0] o_mem_din,
   input  logic [DW-1:0] i_mem_dout,
   input  logic [7:0]    i_sw_in,
   output logic [7:0]    o_led_out
);

   logic [1:0]    w_req;
   logic [1:0]    w_gnt;
   logic          w_any;
   logic          w_sel_dbg;
   logic [1:0]    w_cmd;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_io;
   logic          w_wr;
   logic          w_rd;
   space_e        w_space;
   logic [DW-1:0] w_rdata;

   logic [7:0]    r_mem_addr;
   logic [DW-1:0] r_mem_din;
   logic [7:0]    r_led;
   logic [7:0]    r_sw;
   logic          r_cpu_rvalid;
   logic          r_dbg_rvalid;
   space_e        r_space;

   assign w_req = {is_req(i_dbg_cmd), is_req(i_cpu_cmd)};

   mem_port_arbiter_rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (w_req),
      .i_lock  (i_dbg_lock),
      .o_gnt   (w_gnt)
   );

   assign w_any     = |w_gnt;
   assign w_sel_dbg = w_gnt[1];
   assign w_cmd     = w_sel_dbg ? i_dbg_cmd   : i_cpu_cmd;
   assign w_addr    = w_sel_dbg ? i_dbg_addr  : i_cpu_addr;
   assign w_wdata   = w_sel_dbg ? i_dbg_wdata : i_cpu_wdata;
   assign w_io      = w_addr[AW-1];
   assign w_wr      = w_any & (w_cmd == MWRITE);
   assign w_rd      = w_any & (w_cmd == MREAD);

   always_comb begin
      w_space = SP_RAM;
      if (w_io) begin
         if (w_addr == LED_ADDR) begin
            w_space = SP_LED;
         end else if (w_addr == SW_ADDR) begin
            w_space = SP_SW;
         end else begin
            w_space = SP_NONE;
         end
      end
   end

   // Address/data hold their last granted value so an idle RAM sees no change.
   assign o_mem_write = w_wr & ~w_io;
   assign o_mem_addr  = w_any ? w_addr[7:0] : r_mem_addr;
   assign o_mem_din   = w_any ? w_wdata     : r_mem_din;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem_addr   <= 8'h00;
         r_mem_din    <= '0;
         r_led        <= 8'h00;
         r_sw         <= 8'h00;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
         r_space      <= SP_RAM;
      end else begin
         if (w_any) begin
            r_mem_addr <= w_addr[7:0];
            r_mem_din  <= w_wdata;
         end
         r_cpu_rvalid <= w_rd & ~w_sel_dbg;
         r_dbg_rvalid <= w_rd &  w_sel_dbg;
         if (w_rd) begin
            r_space <= w_space;
            r_sw    <= i_sw_in;
         end
         if (w_wr && (w_space == SP_LED)) begin
            r_led <= w_wdata[7:0];
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (r_space)
         SP_RAM:  w_rdata = i_mem_dout;
         SP_LED:  w_rdata = {{(DW-8){1'b0}}, r_led};
         SP_SW:   w_rdata = {{(DW-8){1'b0}}, r_sw};
         default: w_rdata = '0;
      endcase
   end

   assign o_cpu_gnt    = w_gnt[0];
   assign o_dbg_gnt    = w_gnt[1];
   assign o_cpu_rvalid = r_cpu_rvalid;
   assign o_dbg_rvalid = r_dbg_rvalid;
   assign o_cpu_rdata  = w_rdata;
   assign o_dbg_rdata  = w_rdata;
   assign o_led_out    = r_led;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural
// scoreboard (expected memory image, LED value, last winner, pending read).
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    cpu_cmd, dbg_cmd;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          dbg_lock;
   logic [7:0]    sw_in;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic [7:0]    mem_addr;
   logic          mem_write;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic [7:0]    led_out;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cpu_cmd(cpu_cmd), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .i_dbg_cmd(dbg_cmd), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
      .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
      .i_dbg_lock(dbg_lock),
      .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_din(mem_din),
      .i_mem_dout(mem_dout), .i_sw_in(sw_in), .o_led_out(led_out)
   );

   // Synchronous-read RAM the arbiter drives.
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   int n_pass = 0;
   int n_total = 0;

   logic [DW-1:0] m_mem [256];
   logic [7:0]    m_led;
   logic          m_last;
   logic          m_exp_crv, m_exp_drv;
   logic [DW-1:0] m_exp_rdata;
   logic          m_hold_ok;
   logic [7:0]    m_hold_addr;
   logic [DW-1:0] m_hold_din;

   logic          g_c, g_d, s_any;
   logic [1:0]    s_cmd;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wd;
   logic          n_crv, n_drv;
   logic [DW-1:0] n_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_last = REQ_DBG;
      m_led = 8'h00;
      m_exp_crv = 1'b0;
      m_exp_drv = 1'b0;
      m_hold_ok = 1'b0;
      g_c = 1'b0;
      g_d = 1'b0;
   endtask

   task automatic sample_and_check();
      logic ce, de, exp_we;
      @(negedge clk);
      ce = is_req(cpu_cmd) && !dbg_lock;
      de = is_req(dbg_cmd);
      if (ce && de) begin
         g_c = (m_last == REQ_DBG);
         g_d = !g_c;
      end else begin
         g_c = ce;
         g_d = de;
      end
      check("cpu_gnt", 32'(cpu_gnt), 32'(g_c));
      check("dbg_gnt", 32'(dbg_gnt), 32'(g_d));
      s_any  = g_c || g_d;
      s_cmd  = g_d ? dbg_cmd : cpu_cmd;
      s_addr = g_d ? dbg_addr : cpu_addr;
      s_wd   = g_d ? dbg_wdata : cpu_wdata;
      exp_we = s_any && (s_cmd == MWRITE) && !s_addr[8];
      check("mem_write", 32'(mem_write), 32'(exp_we));
      if (exp_we) begin
         check("mem_addr", 32'(mem_addr), 32'(s_addr[7:0]));
         check("mem_din", 32'(mem_din), 32'(s_wd));
      end else if (!s_any && m_hold_ok) begin
         check("mem_addr_hold", 32'(mem_addr), 32'(m_hold_addr));
         check("mem_din_hold", 32'(mem_din), 32'(m_hold_din));
      end
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_exp_crv));
      check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_exp_drv));
      if (m_exp_crv) check("cpu_rdata", 32'(cpu_rdata), 32'(m_exp_rdata));
      if (m_exp_drv) check("dbg_rdata", 32'(dbg_rdata), 32'(m_exp_rdata));
      check("led_out", 32'(led_out), 32'(m_led));
      n_crv = g_c && (s_cmd == MREAD);
      n_drv = g_d && (s_cmd == MREAD);
      if (!s_addr[8])               n_rdata = m_mem[s_addr[7:0]];
      else if (s_addr == LED_ADDR)  n_rdata = {8'h00, m_led};
      else if (s_addr == SW_ADDR)   n_rdata = {8'h00, sw_in};
      else                          n_rdata = 16'h0000;
   endtask

   task automatic advance();
      @(posedge clk);
      if (s_any) begin
         m_last = g_d ? REQ_DBG : REQ_CPU;
         m_hold_ok = 1'b1;
         m_hold_addr = s_addr[7:0];
         m_hold_din = s_wd;
         if (s_cmd == MWRITE) begin
            if (!s_addr[8]) m_mem[s_addr[7:0]] = s_wd;
            else if (s_addr == LED_ADDR) m_led = s_wd[7:0];
         end
      end
      m_exp_crv = n_crv;
      m_exp_drv = n_drv;
      m_exp_rdata = n_rdata;
      #1;
   endtask

   task automatic step();
      sample_and_check();
      advance();
   endtask

   task automatic pick(output logic [1:0] cmd, output logic [AW-1:0] addr, output logic [DW-1:0] wd);
      int r, a;
      r = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 9));
      if (r < 2)       cmd = MNONE;
      else if (r == 2) cmd = 2'b11;
      else if (r < 7)  cmd = MREAD;
      else             cmd = MWRITE;
      if (a < 7)       addr = {5'b00000, 4'($urandom)};
      else if (a == 7) addr = LED_ADDR;
      else if (a == 8) addr = SW_ADDR;
      else             addr = {1'b1, 8'($urandom)};
      wd = 16'($urandom);
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_cmd = MREAD;  cpu_addr = '0; cpu_wdata = '0;
      dbg_cmd = MREAD;  dbg_addr = '0; dbg_wdata = '0;
      dbg_lock = 1'b0;
      sw_in = 8'h00;
      model_reset();

      // Reset state with both requesting
      @(negedge clk);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      cpu_cmd = MNONE; dbg_cmd = MNONE;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Preload RAM[0..15] through the debug port
      for (int i = 0; i < 16; i++) begin
         dbg_cmd = MWRITE;
         dbg_addr = 9'(i);
         dbg_wdata = (i == 5) ? 16'hACDC : 16'($urandom);
         step();
      end
      dbg_cmd = MNONE;

      // CPU read of address 5
      cpu_cmd = MREAD; cpu_addr = 9'h005;
      sample_and_check();
      check("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
      advance();
      cpu_cmd = MNONE;
      sample_and_check();
      check("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("t1_cpu_rdata", 32'(cpu_rdata), 32'hACDC);
      check("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      advance();

      // Make debug the last winner so the next tie favours the CPU
      dbg_cmd = MREAD; dbg_addr = 9'h007;
      step();

      // Both read continuously: alternation
      cpu_cmd = MREAD; cpu_addr = 9'h001;
      dbg_cmd = MREAD; dbg_addr = 9'h002;
      for (int k = 0; k < 4; k++) begin
         sample_and_check();
         check("alt_cpu_gnt", 32'(cpu_gnt), 32'((k % 2) == 0));
         check("alt_dbg_gnt", 32'(dbg_gnt), 32'((k % 2) == 1));
         advance();
      end
      cpu_cmd = MNONE; dbg_cmd = MNONE;
      step();

      // Write then read-back of address 6
      cpu_cmd = MWRITE; cpu_addr = 9'h006; cpu_wdata = 16'hACDC;
      sample_and_check();
      check("wr6_mem_write", 32'(mem_write), 32'd1);
      advance();
      cpu_cmd = MREAD;
      sample_and_check();
      check("rd6_mem_write", 32'(mem_write), 32'd0);
      advance();
      cpu_cmd = MNONE;
      sample_and_check();
      check("rd6_rdata", 32'(cpu_rdata), 32'hACDC);
      advance();

      // LED write, debug read-back
      cpu_cmd = MWRITE; cpu_addr = LED_ADDR; cpu_wdata = 16'h12A5;
      step();
      cpu_cmd = MNONE;
      dbg_cmd = MREAD; dbg_addr = LED_ADDR;
      step();
      dbg_cmd = MNONE;
      sample_and_check();
      check("led_value", 32'(led_out), 32'h0A5);
      check("led_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
      check("led_dbg_rdata", 32'(dbg_rdata), 32'h00A5);
      advance();

      // Switch read, switches change after the grant edge
      sw_in = 8'h3C;
      cpu_cmd = MREAD; cpu_addr = SW_ADDR;
      step();
      cpu_cmd = MNONE;
      sw_in = 8'h00;
      sample_and_check();
      check("sw_rdata", 32'(cpu_rdata), 32'h003C);
      advance();

      // Unmapped I/O read and write
      cpu_cmd = MREAD; cpu_addr = 9'h1FF;
      step();
      cpu_cmd = MWRITE; cpu_wdata = 16'hFFFF;
      sample_and_check();
      check("io_rdata", 32'(cpu_rdata), 32'h0000);
      check("io_wr_mem_write", 32'(mem_write), 32'd0);
      advance();
      cpu_cmd = MNONE;
      sample_and_check();
      check("io_wr_led", 32'(led_out), 32'h0A5);
      advance();

      // Lock holds off a pending CPU read
      dbg_lock = 1'b1;
      cpu_cmd = MREAD; cpu_addr = 9'h003;
      for (int k = 0; k < 5; k++) begin
         dbg_cmd = (k < 3) ? MWRITE : MREAD;
         dbg_addr = (k < 3) ? 9'(k) : 9'(k - 3);
         dbg_wdata = 16'($urandom);
         sample_and_check();
         check("lock_cpu_gnt", 32'(cpu_gnt), 32'd0);
         advance();
      end
      dbg_cmd = MNONE;
      dbg_lock = 1'b0;
      sample_and_check();
      check("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
      advance();
      cpu_cmd = MNONE;
      step();

      // Reset the cycle after a CPU read grant
      cpu_cmd = MREAD; cpu_addr = 9'h004;
      step();
      rst_n = 1'b0;
      model_reset();
      cpu_cmd = MREAD; dbg_cmd = MREAD; dbg_addr = 9'h008;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("arst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
         check("arst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
         check("arst_cpu_gnt", 32'(cpu_gnt), 32'd0);
         check("arst_dbg_gnt", 32'(dbg_gnt), 32'd0);
         check("arst_led", 32'(led_out), 32'd0);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      sample_and_check();
      check("post_rst_tie_cpu", 32'(cpu_gnt), 32'd1);
      advance();
      cpu_cmd = MNONE; dbg_cmd = MNONE;
      step();

      // Randomized traffic; a request is held until granted
      g_c = 1'b0; g_d = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (g_c || !is_req(cpu_cmd)) pick(cpu_cmd, cpu_addr, cpu_wdata);
         if (g_d || !is_req(dbg_cmd)) pick(dbg_cmd, dbg_addr, dbg_wdata);
         if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
         sw_in = 8'($urandom);
         step();
      end
      dbg_lock = 1'b0;
      cpu_cmd = MNONE; dbg_cmd = MNONE;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
